alu_mc: RTL and testbench

Parametrised multi-cycle ALU for the datapath, the successor to the 16-bit single-cycle ALU. It adds configurable width, SUB/OR, and iterative multiply and unsigned divide/remainder behind a start/busy/done handshake. It keeps the registered result, the N/Z/P condition-code register and the PSR restore path from memory. It sits between the register-file read ports and the writeback mux, and is sequenced by the control unit.

---
 rtl/alu_mc.sv | 189 ++++++++++++++++++
 tb/tb_alu_mc.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith ops plus iterative multiply and
// unsigned divide/remainder, with N/Z/P condition codes and PSR restore.
//   state  | meaning
//   S_IDLE | accepting start; single-cycle results load directly
//   S_MUL  | shift-add multiply, one multiplier bit per edge
//   S_DIV  | restoring divide, one quotient bit per edge
module alu_mc #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  input  logic             start,
  input  logic             flag_en,
  input  logic             psr_ld,
  input  logic [2:0]       psr_in,
  output logic [WIDTH-1:0] alu,
  output logic [WIDTH-1:0] alu_out,
  output logic             z,
  output logic             n,
  output logic             p,
  output logic             busy,
  output logic             done,
  output logic             dbz
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);
  localparam logic [SHW-1:0]   LAST    = SHW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] acc;
  logic [3:0]       op_q;
  logic             flag_q;
  logic [SHW-1:0]   cnt;

  logic                    sh_big;
  logic [SHW-1:0]          sh_amt;
  logic signed [WIDTH-1:0] sra_v;

  always_comb begin
    sh_big = (b >= WIDTH_V);
    sh_amt = b[SHW-1:0];
    sra_v  = $signed(a) >>> sh_amt;
    case (op)
      4'd0:    alu = a + b;
      4'd1:    alu = a & b;
      4'd2:    alu = a ^ b;
      4'd3:    alu = sh_big ? '0 : (a << sh_amt);
      4'd4:    alu = sh_big ? '0 : (a >> sh_amt);
      4'd5:    alu = sh_big ? {WIDTH{a[WIDTH-1]}} : sra_v;
      4'd6:    alu = a;
      4'd7:    alu = b;
      4'd8:    alu = a - b;
      4'd9:    alu = a | b;
      default: alu = b;
    endcase
  end

  // Iteration step. In DIV, opa carries the dividend out of its MSB while the
  // quotient bits shift in at the LSB; acc holds the partial remainder.
  logic [WIDTH-1:0] mul_sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_diff;
  logic             div_ge;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] quo_nx;
  logic             last;
  logic             multi_op;

  always_comb begin
    mul_sum  = acc + (opb[0] ? opa : '0);
    rem_sh   = {acc, opa[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, opb};
    div_ge   = ~rem_diff[WIDTH];
    rem_nx   = div_ge ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    quo_nx   = {opa[WIDTH-2:0], div_ge};
    last     = (cnt == LAST);
    multi_op = (op == 4'd10) || (op == 4'd11) || (op == 4'd12);
  end

  logic             ld_en;
  logic [WIDTH-1:0] ld_res;
  logic             ld_flag;
  logic             ld_dbz;

  always_comb begin
    ld_en   = 1'b0;
    ld_res  = alu;
    ld_flag = flag_en;
    ld_dbz  = 1'b0;
    case (state)
      S_IDLE: ld_en = start && !multi_op;
      S_MUL: begin
        ld_en   = last;
        ld_res  = mul_sum;
        ld_flag = flag_q;
      end
      S_DIV: begin
        ld_en   = last;
        ld_res  = (op_q == 4'd12) ? rem_nx : quo_nx;
        ld_flag = flag_q;
        ld_dbz  = (opb == '0);
      end
      default: ld_en = 1'b0;
    endcase
  end

  // All state moves on the falling edge, the datapath latch edge.
  always_ff @(negedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      alu_out <= '0;
      z       <= 1'b1;
      n       <= 1'b0;
      p       <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      dbz     <= 1'b0;
      opa     <= '0;
      opb     <= '0;
      acc     <= '0;
      op_q    <= '0;
      flag_q  <= 1'b0;
      cnt     <= '0;
    end else begin
      done <= ld_en;
      dbz  <= ld_en && ld_dbz;
      if (ld_en) begin
        alu_out <= ld_res;
        if (ld_flag) begin
          z <= (ld_res == '0);
          n <= ld_res[WIDTH-1];
          p <= ~ld_res[WIDTH-1];
        end
      end
      // Memory restore wins over a same-edge flag update.
      if (psr_ld) begin
        n <= psr_in[2];
        z <= psr_in[1];
        p <= psr_in[0];
      end
      case (state)
        S_IDLE: begin
          if (start && multi_op) begin
            opa    <= a;
            opb    <= b;
            op_q   <= op;
            flag_q <= flag_en;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= (op == 4'd10) ? S_MUL : S_DIV;
          end
        end
        S_MUL: begin
          acc <= mul_sum;
          opa <= opa << 1;
          opb <= opb >> 1;
          cnt <= cnt + 1'b1;
          if (last) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        S_DIV: begin
          acc <= rem_nx;
          opa <= quo_nx;
          cnt <= cnt + 1'b1;
          if (last) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: three instances (WIDTH 8/16/32) run the same
// stimulus in lockstep; a reference model predicts each width's results.
module tb_alu_mc;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        flag_en;
  logic        psr_ld;
  logic [3:0]  op;
  logic [2:0]  psr_in;
  logic [31:0] a_v;
  logic [31:0] b_v;

  wire [7:0]  alu8, out8;
  wire [15:0] alu16, out16;
  wire [31:0] alu32, out32;
  wire [2:0]  z_v, n_v, p_v, busy_v, done_v, dbz_v;
  wire [31:0] alu_v [3];
  wire [31:0] out_v [3];

  assign alu_v[0] = {24'd0, alu8};
  assign alu_v[1] = {16'd0, alu16};
  assign alu_v[2] = alu32;
  assign out_v[0] = {24'd0, out8};
  assign out_v[1] = {16'd0, out16};
  assign out_v[2] = out32;

  alu_mc #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .a(a_v[7:0]), .b(b_v[7:0]), .op(op),
    .start(start), .flag_en(flag_en), .psr_ld(psr_ld), .psr_in(psr_in),
    .alu(alu8), .alu_out(out8), .z(z_v[0]), .n(n_v[0]), .p(p_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .dbz(dbz_v[0]));

  alu_mc #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst_n(rst_n), .a(a_v[15:0]), .b(b_v[15:0]), .op(op),
    .start(start), .flag_en(flag_en), .psr_ld(psr_ld), .psr_in(psr_in),
    .alu(alu16), .alu_out(out16), .z(z_v[1]), .n(n_v[1]), .p(p_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .dbz(dbz_v[1]));

  alu_mc #(.WIDTH(32)) u_w32 (
    .clk(clk), .rst_n(rst_n), .a(a_v), .b(b_v), .op(op),
    .start(start), .flag_en(flag_en), .psr_ld(psr_ld), .psr_in(psr_in),
    .alu(alu32), .alu_out(out32), .z(z_v[2]), .n(n_v[2]), .p(p_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .dbz(dbz_v[2]));

  initial clk = 1'b1;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic        n;
    logic        z;
    logic        p;
    logic        dbz;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  logic [2:0] mf [3];
  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp_v);
    end
  endtask

  function automatic int wsz(input int i);
    return (i == 0) ? 8 : (i == 1) ? 16 : 32;
  endfunction

  function automatic int qsz(input int i);
    case (i)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic qpush(input int i, input exp_t e);
    case (i)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  function automatic exp_t qpop(input int i);
    case (i)
      0: return q0.pop_front();
      1: return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  function automatic logic [31:0] model(input int w, input logic [3:0] o,
                                        input logic [31:0] av, input logic [31:0] bv);
    logic [63:0] m, x, y, r, wv;
    logic sg;
    m  = (64'd1 << w) - 64'd1;
    wv = 64'(w);
    x  = {32'd0, av} & m;
    y  = {32'd0, bv} & m;
    sg = x[w-1];
    case (o)
      4'd0:  r = x + y;
      4'd1:  r = x & y;
      4'd2:  r = x ^ y;
      4'd3:  r = (y >= wv) ? 64'd0 : (x << y);
      4'd4:  r = (y >= wv) ? 64'd0 : (x >> y);
      4'd5:  r = (y >= wv) ? (sg ? m : 64'd0) : ((x >> y) | (sg ? (m & ~(m >> y)) : 64'd0));
      4'd6:  r = x;
      4'd7:  r = y;
      4'd8:  r = x - y;
      4'd9:  r = x | y;
      4'd10: r = x * y;
      4'd11: r = (y == 64'd0) ? m : (x / y);
      4'd12: r = (y == 64'd0) ? x : (x % y);
      default: r = y;
    endcase
    r = r & m;
    return r[31:0];
  endfunction

  // Result monitor: sample away from the falling (active) edge.
  exp_t mon_e;
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (done_v[i]) begin
        if (qsz(i) == 0) begin
          chk($sformatf("spurious_done_w%0d", wsz(i)), done_v[i], 0);
        end else begin
          mon_e = qpop(i);
          chk($sformatf("alu_out_w%0d", wsz(i)), out_v[i], mon_e.res);
          chk($sformatf("flags_w%0d", wsz(i)), {n_v[i], z_v[i], p_v[i]},
              {mon_e.n, mon_e.z, mon_e.p});
          chk($sformatf("dbz_w%0d", wsz(i)), dbz_v[i], mon_e.dbz);
        end
      end
    end
  end

  task automatic issue(input logic [3:0] o, input logic [31:0] av, input logic [31:0] bv,
                       input logic fe, input logic pl, input logic [2:0] pin, input int poke);
    logic multi, all_idle;
    logic [31:0] r, msk;
    int w;
    int cnt [3];
    exp_t e;
    multi = (o == 4'd10) || (o == 4'd11) || (o == 4'd12);
    op = o; a_v = av; b_v = bv; flag_en = fe; psr_ld = pl; psr_in = pin; start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      w   = wsz(i);
      msk = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      r   = model(w, o, av, bv);
      if (multi && pl) mf[i] = pin;
      if (fe) mf[i] = {r[w-1], (r == 32'd0), ~r[w-1]};
      if (!multi && pl) mf[i] = pin;
      e = '{res: r, n: mf[i][2], z: mf[i][1], p: mf[i][0],
            dbz: (multi && (o != 4'd10) && ((bv & msk) == 32'd0))};
      qpush(i, e);
      cnt[i] = 0;
    end
    @(posedge clk);
    start = 1'b0; psr_ld = 1'b0;
    if (!multi) begin
      for (int i = 0; i < 3; i++) chk($sformatf("busy_single_w%0d", wsz(i)), busy_v[i], 0);
    end else begin
      for (int k = 1; k <= 60; k++) begin
        all_idle = 1'b1;
        for (int i = 0; i < 3; i++) begin
          if (busy_v[i]) begin
            cnt[i]++;
            all_idle = 1'b0;
          end
        end
        if (all_idle) break;
        start = (k == poke);
        op    = (k == poke) ? 4'd0 : o;
        @(posedge clk);
      end
      start = 1'b0; op = o;
      for (int i = 0; i < 3; i++) chk($sformatf("busy_len_w%0d", wsz(i)), cnt[i], wsz(i));
    end
  endtask

  task automatic check_reset(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_out_w%0d", tag, wsz(i)), out_v[i], 0);
      chk($sformatf("%s_nzp_w%0d", tag, wsz(i)), {n_v[i], z_v[i], p_v[i]}, 3'b010);
      chk($sformatf("%s_busy_w%0d", tag, wsz(i)), busy_v[i], 0);
      chk($sformatf("%s_done_w%0d", tag, wsz(i)), done_v[i], 0);
      chk($sformatf("%s_dbz_w%0d", tag, wsz(i)), dbz_v[i], 0);
      mf[i] = 3'b010;
    end
  endtask

  logic [3:0]  r_op;
  logic [31:0] r_a, r_b;

  initial begin
    rst_n = 1'b0; start = 1'b0; flag_en = 1'b0; psr_ld = 1'b0;
    op = 4'd0; psr_in = 3'b000; a_v = 32'd0; b_v = 32'd0;
    repeat (2) @(posedge clk);
    check_reset("rst_init");
    rst_n = 1'b1;

    // ADD overflow into sign bit, then isolated done pulse
    issue(4'd0, 32'h0000_7FFF, 32'd1, 1'b1, 1'b0, 3'b000, 0);
    @(posedge clk);
    // back-to-back: SUB to zero with flags, SRA by oversized amount without flags
    issue(4'd8, 32'd5, 32'd5, 1'b1, 1'b0, 3'b000, 0);
    issue(4'd5, 32'h0000_8000, 32'd20, 1'b0, 1'b0, 3'b000, 0);
    issue(4'd3, 32'h0000_00A5, 32'd3, 1'b1, 1'b0, 3'b000, 0);
    issue(4'd4, 32'h8000_8080, 32'd40, 1'b1, 1'b0, 3'b000, 0);
    issue(4'd9, 32'h0000_1200, 32'h0000_0034, 1'b1, 1'b0, 3'b000, 0);
    // multiply with a start poked mid-operation
    issue(4'd10, 32'hFFFF_FFFD, 32'd7, 1'b1, 1'b0, 3'b000, 5);
    issue(4'd11, 32'd100, 32'd7, 1'b1, 1'b0, 3'b000, 0);
    issue(4'd12, 32'd100, 32'd7, 1'b1, 1'b0, 3'b000, 0);
    issue(4'd11, 32'd9, 32'd0, 1'b1, 1'b0, 3'b000, 0);
    issue(4'd12, 32'd9, 32'd0, 1'b0, 1'b0, 3'b000, 0);
    // psr restore overrides the same-edge flag update of a zero result
    issue(4'd8, 32'd3, 32'd3, 1'b1, 1'b1, 3'b100, 0);
    @(posedge clk);

    // standalone restore while idle
    psr_ld = 1'b1; psr_in = 3'b011;
    @(posedge clk);
    psr_ld = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("psr_idle_w%0d", wsz(i)), {n_v[i], z_v[i], p_v[i]}, 3'b011);
      mf[i] = 3'b011;
    end

    // reset asserted at edge 8 of a divide: aborted, no done
    op = 4'd11; a_v = 32'd100; b_v = 32'd7; flag_en = 1'b1; start = 1'b1;
    @(posedge clk);
    start = 1'b0;
    repeat (7) @(posedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    check_reset("rst_abort");
    rst_n = 1'b1;

    // random mix
    for (int t = 0; t < 30; t++) begin
      r_op = 4'($urandom_range(0, 15));
      r_a  = $urandom;
      r_b  = (t % 4 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      if (t == 7) r_b = 32'd0;
      issue(r_op, r_a, r_b, 1'($urandom_range(0, 1)), 1'b0, 3'b000, 0);
    end
    @(posedge clk);

    // combinational result follows inputs with no clock
    for (int t = 0; t < 20; t++) begin
      op  = 4'(t % 10);
      a_v = $urandom;
      b_v = (t % 3 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      #1;
      for (int i = 0; i < 3; i++)
        chk($sformatf("alu_comb_op%0d_w%0d", op, wsz(i)), alu_v[i], model(wsz(i), op, a_v, b_v));
    end
    @(posedge clk);
    @(posedge clk);
    for (int i = 0; i < 3; i++) chk($sformatf("sb_left_w%0d", wsz(i)), qsz(i), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
